// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and types for the register-file writeback path.
package cpu_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  typedef enum logic {SRC_ALU, SRC_MEM} wb_src_t;
  typedef logic [1:0] pend_cnt_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; bit 0 is the ALU, bit 1 the memory unit.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  wb_src_t last_grant_q, last_grant_d;
  always_comb begin
    grant        = &req ? (last_grant_q == SRC_MEM ? 2'b01 : 2'b10) : req;
    last_grant_d = grant[1] ? SRC_MEM : grant[0] ? SRC_ALU : last_grant_q;
  end
  // Resetting to MEM lets the ALU win the first contention.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last_grant_q <= SRC_MEM;
    else          last_grant_q <= last_grant_d;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between ALU and memory
// writeback, and tracks pending writes per register for hazard stalls.
module regfile_write_arbiter #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                rsv_ready,
  output logic                rf_write,
  output logic [ADDR_W-1:0]   rf_rd_addr,
  output logic [DATA_W-1:0]   rf_data,
  output logic [NUM_REGS-1:0] busy,
  output logic                err_underflow
);
  logic [1:0]          grant;
  logic                rf_write_q;
  logic [ADDR_W-1:0]   rf_rd_addr_q, rf_rd_addr_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] inc, dec;
  cpu_pkg::pend_cnt_t  cnt_q [NUM_REGS];
  cpu_pkg::pend_cnt_t  cnt_d [NUM_REGS];

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({mem_valid, alu_valid}),
    .grant   (grant)
  );

  assign alu_ready     = grant[0];
  assign mem_ready     = grant[1];
  assign rsv_ready     = cnt_q[rsv_addr] != 2'd3;
  assign rf_write      = rf_write_q;
  assign rf_rd_addr    = rf_rd_addr_q;
  assign rf_data       = rf_data_q;
  assign err_underflow = err_q;

  always_comb begin
    rf_rd_addr_d = grant[1] ? mem_addr : grant[0] ? alu_addr : rf_rd_addr_q;
    rf_data_d    = grant[1] ? mem_data : grant[0] ? alu_data : rf_data_q;
    err_d        = err_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i]   = rsv_valid && rsv_ready && rsv_addr == ADDR_W'(i);
      dec[i]   = rf_write_q && rf_rd_addr_q == ADDR_W'(i);
      busy[i]  = cnt_q[i] != '0;
      // A retire with no matching reservation saturates at 0 and is flagged.
      err_d    = err_d | (dec[i] && !inc[i] && cnt_q[i] == '0);
      cnt_d[i] = (inc[i] && !dec[i]) ? cnt_q[i] + 2'd1 :
                 (dec[i] && !inc[i] && cnt_q[i] != '0) ? cnt_q[i] - 2'd1 : cnt_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rf_write_q   <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_data_q    <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      rf_write_q   <= |grant;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_data_q    <= rf_data_d;
      err_q        <= err_d;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table for arbitration plus directed scoreboard,
// underflow and asynchronous reset sequences.
module tb_regfile_write_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid, rsv_valid;
  logic [2:0]  alu_addr, mem_addr, rsv_addr;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, rsv_ready;
  logic        rf_write, err_underflow;
  logic [2:0]  rf_rd_addr;
  logic [15:0] rf_data;
  logic [7:0]  busy;

  typedef struct {
    logic av; logic [2:0] aa; logic [15:0] ad;
    logic mv; logic [2:0] ma; logic [15:0] md;
    logic ar; logic mr;
  } vec_t;
  typedef struct { logic [2:0] a; logic [15:0] d; } wr_t;

  vec_t vecs [10];
  wr_t  sb [$];
  int   tests = 0, fails = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .rf_write(rf_write), .rf_rd_addr(rf_rd_addr), .rf_data(rf_data),
    .busy(busy), .err_underflow(err_underflow)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    sb.delete();
    step();
    step();
    reset_n = 1;
  endtask

  task automatic check_out();
    wr_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rf_write", {31'd0, rf_write}, 1);
      chk("rf_rd_addr", {29'd0, rf_rd_addr}, {29'd0, e.a});
      chk("rf_data", {16'd0, rf_data}, {16'd0, e.d});
    end else chk("rf_write idle", {31'd0, rf_write}, 0);
  endtask

  initial begin
    vecs[0] = '{1, 3'd0, 16'h0001, 0, 3'd0, 16'h0000, 1, 0};
    vecs[1] = '{0, 3'd0, 16'h0000, 1, 3'd1, 16'h0055, 0, 1};
    vecs[2] = '{1, 3'd7, 16'h00AB, 1, 3'd3, 16'h1234, 1, 0};
    vecs[3] = '{1, 3'd7, 16'h00AB, 1, 3'd3, 16'h1234, 0, 1};
    vecs[4] = '{1, 3'd7, 16'h00AB, 1, 3'd3, 16'h1234, 1, 0};
    vecs[5] = '{1, 3'd7, 16'h00AB, 1, 3'd3, 16'h1234, 0, 1};
    vecs[6] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0};
    vecs[7] = '{0, 3'd0, 16'h0000, 1, 3'd6, 16'hBEEF, 0, 1};
    vecs[8] = '{1, 3'd2, 16'h2222, 1, 3'd5, 16'h5555, 1, 0};
    vecs[9] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0};
    alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0; rsv_addr = 0;
    do_reset();
    @(negedge clock);
    chk("reset rf_write", {31'd0, rf_write}, 0);
    chk("reset rf_rd_addr", {29'd0, rf_rd_addr}, 0);
    chk("reset rf_data", {16'd0, rf_data}, 0);
    chk("reset busy", {24'd0, busy}, 0);
    chk("reset err", {31'd0, err_underflow}, 0);
    chk("reset rsv_ready", {31'd0, rsv_ready}, 1);
    step();

    for (int i = 0; i < 10; i++) begin
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
      @(negedge clock);
      check_out();
      chk($sformatf("alu_ready v%0d", i), {31'd0, alu_ready}, {31'd0, vecs[i].ar});
      chk($sformatf("mem_ready v%0d", i), {31'd0, mem_ready}, {31'd0, vecs[i].mr});
      if (vecs[i].ar) sb.push_back('{vecs[i].aa, vecs[i].ad});
      else if (vecs[i].mr) sb.push_back('{vecs[i].ma, vecs[i].md});
      step();
    end
    idle();
    @(negedge clock);
    check_out();
    chk("scoreboard drained", sb.size(), 0);

    do_reset();
    rsv_addr = 5; rsv_valid = 1;
    repeat (3) begin
      @(negedge clock);
      chk("rsv_ready r5 free", {31'd0, rsv_ready}, 1);
      step();
    end
    rsv_valid = 0;
    @(negedge clock);
    chk("busy5 reserved", {31'd0, busy[5]}, 1);
    chk("rsv_ready r5 full", {31'd0, rsv_ready}, 0);
    step();
    alu_valid = 1; alu_addr = 5; alu_data = 16'h0505;
    repeat (3) step();
    alu_valid = 0;
    @(negedge clock);
    chk("third write r5", {31'd0, rf_write}, 1);
    chk("busy5 during third", {31'd0, busy[5]}, 1);
    step();
    @(negedge clock);
    chk("busy5 retired", {31'd0, busy[5]}, 0);
    chk("err after r5", {31'd0, err_underflow}, 0);

    rsv_addr = 2; rsv_valid = 1;
    step();
    rsv_valid = 0;
    alu_valid = 1; alu_addr = 2; alu_data = 16'h2020;
    step();
    alu_valid = 0; rsv_valid = 1;
    @(negedge clock);
    chk("r2 write", {31'd0, rf_write}, 1);
    chk("r2 addr", {29'd0, rf_rd_addr}, 2);
    step();
    rsv_valid = 0;
    @(negedge clock);
    chk("busy2 same edge", {31'd0, busy[2]}, 1);
    alu_valid = 1;
    step();
    alu_valid = 0;
    step();
    @(negedge clock);
    chk("busy2 retired", {31'd0, busy[2]}, 0);
    chk("err after r2", {31'd0, err_underflow}, 0);

    alu_valid = 1; alu_addr = 4; alu_data = 16'h4444;
    step();
    alu_valid = 0;
    @(negedge clock);
    chk("r4 write", {31'd0, rf_write}, 1);
    chk("r4 data", {16'd0, rf_data}, 16'h4444);
    chk("err before r4 edge", {31'd0, err_underflow}, 0);
    step();
    @(negedge clock);
    chk("err underflow", {31'd0, err_underflow}, 1);
    repeat (3) step();
    @(negedge clock);
    chk("err sticky", {31'd0, err_underflow}, 1);

    rsv_addr = 6; rsv_valid = 1;
    step();
    rsv_valid = 0;
    alu_valid = 1; alu_addr = 1; alu_data = 16'h1111;
    step();
    alu_valid = 0;
    chk("pre-reset write", {31'd0, rf_write}, 1);
    chk("pre-reset busy6", {31'd0, busy[6]}, 1);
    #2 reset_n = 0;
    #1;
    chk("async rf_write", {31'd0, rf_write}, 0);
    chk("async busy", {24'd0, busy}, 0);
    chk("async err", {31'd0, err_underflow}, 0);
    chk("async rf_data", {16'd0, rf_data}, 0);
    step();
    reset_n = 1;
    alu_valid = 1; alu_addr = 7; alu_data = 16'h7777;
    mem_valid = 1; mem_addr = 3; mem_data = 16'h3333;
    @(negedge clock);
    chk("post-reset alu_ready", {31'd0, alu_ready}, 1);
    chk("post-reset mem_ready", {31'd0, mem_ready}, 0);
    step();
    idle();
    @(negedge clock);
    chk("post-reset rf_data", {16'd0, rf_data}, 16'h7777);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
